// File: rtl/phase_link_pkg.sv
// Shared types for the phase update link: sync marker, {channel, phase} word and decoder states.
package phase_link_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef struct packed {
        logic [7:0] channel;
        logic [7:0] phase;
    } phase_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_CHAN,
        ST_PHASE,
        ST_CSUM,
        ST_REPLAY
    } dec_state_t;

endpackage

// File: rtl/phase_frame_decoder_pair_buffer.sv
// Pair store for one frame: single write port, registered read port that holds between reads.
module pair_buffer
    import phase_link_pkg::*;
#(
    parameter int MAX_PAIRS = 64,
    parameter int IDX_W     = (MAX_PAIRS > 1) ? $clog2(MAX_PAIRS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  phase_word_t       wr_data_i,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output phase_word_t       rd_data_o
);

    phase_word_t mem_q [MAX_PAIRS];
    phase_word_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/phase_frame_decoder.sv
// Deframes SYNC,N,(chan,phase)*N[,CSUM] into {chan,phase} strobes; PHASE_FRAME_CSUM_EN buffers and
// replays only checksum-verified frames, otherwise pairs stream out one cycle after their phase byte.
module phase_frame_decoder
    import phase_link_pkg::*;
#(
    parameter int         MAX_PAIRS = 64,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] phase_data,
    output logic        phase_en,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    dec_state_t state_q;
    logic [7:0] n_q;
    logic [7:0] cnt_q;
    logic [7:0] chan_q;
    logic       phase_en_q;
    logic       frame_done_q;
    logic       frame_err_q;
    logic [7:0] err_count_q;
    logic [7:0] err_count_d;
    logic       accept;
    logic       n_bad;
    logic       last_pair;
    logic       err_now;

    assign accept      = in_valid && in_ready;
    assign n_bad       = (in_byte == 8'd0) || (int'(in_byte) > MAX_PAIRS);
    assign last_pair   = ((cnt_q + 8'd1) == n_q);
    assign err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

`ifdef PHASE_FRAME_CSUM_EN
    localparam int IDX_W = (MAX_PAIRS > 1) ? $clog2(MAX_PAIRS) : 1;

    logic [7:0]       csum_q;
    logic             csum_ok;
    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    phase_word_t      wr_data;
    phase_word_t      rd_data;

    assign in_ready = !rst && (state_q != ST_REPLAY);
    assign csum_ok  = (in_byte == csum_q);
    assign err_now  = accept && (((state_q == ST_COUNT) && n_bad) ||
                                 ((state_q == ST_CSUM) && !csum_ok));
    assign wr_en    = accept && (state_q == ST_PHASE);
    assign wr_data  = '{channel: chan_q, phase: in_byte};
    // Entry 0 is fetched while the checksum byte is accepted so the first word lands one cycle later.
    assign rd_en    = (accept && (state_q == ST_CSUM) && csum_ok) ||
                      ((state_q == ST_REPLAY) && (cnt_q < n_q));
    assign rd_idx   = (state_q == ST_REPLAY) ? cnt_q[IDX_W-1:0] : '0;

    pair_buffer #(
        .MAX_PAIRS (MAX_PAIRS),
        .IDX_W     (IDX_W)
    ) u_pair_buffer (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_idx_i  (cnt_q[IDX_W-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    assign phase_data = rd_data;
`else
    logic [15:0] phase_data_q;
    logic        done_pend_q;

    assign in_ready   = !rst;
    assign err_now    = accept && (state_q == ST_COUNT) && n_bad;
    assign phase_data = phase_data_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            cnt_q        <= '0;
            chan_q       <= '0;
            phase_en_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
`ifdef PHASE_FRAME_CSUM_EN
            csum_q       <= '0;
`else
            phase_data_q <= '0;
            done_pend_q  <= 1'b0;
`endif
        end else begin
            phase_en_q  <= 1'b0;
            frame_err_q <= err_now;
            if (err_now) begin
                err_count_q <= err_count_d;
            end
`ifdef PHASE_FRAME_CSUM_EN
            frame_done_q <= 1'b0;
`else
            frame_done_q <= done_pend_q;
            done_pend_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (accept && (in_byte == SYNC_BYTE)) begin
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (accept) begin
                        if (n_bad) begin
                            state_q <= ST_IDLE;
                        end else begin
                            n_q     <= in_byte;
                            cnt_q   <= '0;
`ifdef PHASE_FRAME_CSUM_EN
                            csum_q  <= in_byte;
`endif
                            state_q <= ST_CHAN;
                        end
                    end
                end
                ST_CHAN: begin
                    if (accept) begin
                        chan_q  <= in_byte;
`ifdef PHASE_FRAME_CSUM_EN
                        csum_q  <= csum_q ^ in_byte;
`endif
                        state_q <= ST_PHASE;
                    end
                end
                ST_PHASE: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 8'd1;
`ifdef PHASE_FRAME_CSUM_EN
                        csum_q  <= csum_q ^ in_byte;
                        state_q <= last_pair ? ST_CSUM : ST_CHAN;
`else
                        phase_data_q <= {chan_q, in_byte};
                        phase_en_q   <= 1'b1;
                        done_pend_q  <= last_pair;
                        state_q      <= last_pair ? ST_IDLE : ST_CHAN;
`endif
                    end
                end
`ifdef PHASE_FRAME_CSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        if (csum_ok) begin
                            cnt_q      <= 8'd1;
                            phase_en_q <= 1'b1;
                            state_q    <= ST_REPLAY;
                        end else begin
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                ST_REPLAY: begin
                    if (cnt_q < n_q) begin
                        cnt_q      <= cnt_q + 8'd1;
                        phase_en_q <= 1'b1;
                    end else begin
                        frame_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign phase_en   = phase_en_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;

endmodule
